// File: rtl/router_pkg.sv
// Shared router definitions for the wormhole switch allocator.
//
// Contents:
//   NUM_PORTS          number of router ports (5)
//   PORT_NORTH..LOCAL  port index constants, also the bit order of every
//                      per-port vector in the router
//   out_state_e        per-output wormhole state (idle or locked to an owner)
//   is_onehot5()       true when exactly one of five bits is set
//   next_port()        round-robin successor of a port index, wrapping 4 -> 0
package router_pkg;

    localparam int NUM_PORTS  = 5;

    localparam int PORT_NORTH = 0;
    localparam int PORT_EAST  = 1;
    localparam int PORT_SOUTH = 2;
    localparam int PORT_WEST  = 3;
    localparam int PORT_LOCAL = 4;

    typedef enum logic {
        OUT_IDLE   = 1'b0,
        OUT_LOCKED = 1'b1
    } out_state_e;

    function automatic logic is_onehot5(input logic [4:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

    function automatic logic [2:0] next_port(input logic [2:0] p);
        return (p >= 3'(PORT_LOCAL)) ? 3'(PORT_NORTH) : p + 3'd1;
    endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational 5-way round-robin picker.
//
// Ports:
//   req  [4:0]  request vector, one bit per input port
//   ptr  [2:0]  highest-priority port index (values above 4 behave as 0)
//   gnt  [4:0]  one-hot grant of the first requester at or after ptr,
//               scanning upward and wrapping 4 -> 0; zero when req is zero
module rr_pick5
    import router_pkg::*;
(
    input  logic [4:0] req,
    input  logic [2:0] ptr,
    output logic [4:0] gnt
);

    logic [2:0] idx;
    logic       found;

    // Walk the five ports starting at the pointer and stop at the first request.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = (ptr > 3'(PORT_LOCAL)) ? 3'(PORT_NORTH) : ptr;
        for (int k = 0; k < 5; k++) begin
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
            idx = next_port(idx);
        end
    end

endmodule

// File: rtl/wormhole_switch_allocator.sv
// Wormhole switch allocator for a 5-port router.
//
// Each output is either idle or locked to one input for the duration of a
// packet. Idle outputs arbitrate among head flits with a round-robin pointer;
// locked outputs pass only their owner's body/tail flits. Grants are produced
// in the same cycle as the requests.
//
// Ports:
//   clk                     single clock
//   rst                     synchronous active-high reset
//   sa_request   [4:0]      per-input flit ready
//   outport_req  [24:0]     one-hot requested output per input, [5i+4:5i]
//   is_head      [4:0]      per-input head flit flag
//   is_tail      [4:0]      per-input tail flit flag
//   valid_downstream_ports  per-output on/off flow control, 1 = on
//   sa_grant     [4:0]      per-input grant (combinational)
//   xbar_sel     [24:0]     one-hot source input per output, [5o+4:5o]
//   out_locked   [4:0]      registered per-output lock status
//   proto_error  [4:0]      registered sticky per-input protocol error
module wormhole_switch_allocator #(
    parameter int NUM_PORTS = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           sa_request,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] outport_req,
    input  logic [NUM_PORTS-1:0]           is_head,
    input  logic [NUM_PORTS-1:0]           is_tail,
    input  logic [NUM_PORTS-1:0]           valid_downstream_ports,
    output logic [NUM_PORTS-1:0]           sa_grant,
    output logic [NUM_PORTS*NUM_PORTS-1:0] xbar_sel,
    output logic [NUM_PORTS-1:0]           out_locked,
    output logic [NUM_PORTS-1:0]           proto_error
);

    import router_pkg::*;

    // Two-dimensional vectors below are indexed [output][input].
    logic [NUM_PORTS-1:0]                req_valid;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req_to;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] head_req;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] pick_gnt;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] out_gnt;

    out_state_e                    state_q [NUM_PORTS];
    out_state_e                    state_d [NUM_PORTS];
    logic [NUM_PORTS-1:0][2:0]     owner_q, owner_d;
    logic [NUM_PORTS-1:0][2:0]     ptr_q, ptr_d;
    logic [NUM_PORTS-1:0]          err_q, err_d;
    logic [NUM_PORTS-1:0]          locked_q, locked_d;

    // A request only counts when its output select is exactly one-hot.
    always_comb begin
        req_valid = '0;
        req_to    = '0;
        head_req  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_valid[i] = sa_request[i] && is_onehot5(outport_req[NUM_PORTS*i +: NUM_PORTS]);
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                req_to[o][i]   = req_valid[i] && outport_req[NUM_PORTS*i + o];
                head_req[o][i] = req_to[o][i] && is_head[i];
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_pick
        rr_pick5 u_pick (
            .req (head_req[o]),
            .ptr (ptr_q[o]),
            .gnt (pick_gnt[o])
        );
    end

    // Per-output grant decision, next lock state and protocol error detection.
    // Errors are flagged regardless of flow control since they describe the
    // flit stream itself, not whether it could move this cycle.
    always_comb begin
        out_gnt = '0;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
        for (int o = 0; o < NUM_PORTS; o++) begin
            state_d[o] = state_q[o];
        end

        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sa_request[i] && !req_valid[i]) begin
                err_d[i] = 1'b1;
            end
        end

        for (int o = 0; o < NUM_PORTS; o++) begin
            if (state_q[o] == OUT_IDLE) begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (req_to[o][i] && !is_head[i]) begin
                        err_d[i] = 1'b1;
                    end
                end
                if (valid_downstream_ports[o]) begin
                    out_gnt[o] = pick_gnt[o];
                end
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (out_gnt[o][i]) begin
                        ptr_d[o] = next_port(3'(i));
                        if (!is_tail[i]) begin
                            state_d[o] = OUT_LOCKED;
                            owner_d[o] = 3'(i);
                        end
                    end
                end
            end else begin
                if (req_to[o][owner_q[o]]) begin
                    if (is_head[owner_q[o]]) begin
                        err_d[owner_q[o]] = 1'b1;
                    end else if (valid_downstream_ports[o]) begin
                        out_gnt[o][owner_q[o]] = 1'b1;
                        if (is_tail[owner_q[o]]) begin
                            state_d[o] = OUT_IDLE;
                        end
                    end
                end
            end
        end

        if (rst) begin
            out_gnt = '0;
        end

        for (int o = 0; o < NUM_PORTS; o++) begin
            locked_d[o] = (state_d[o] == OUT_LOCKED);
        end
    end

    // Each input targets a single output, so OR-ing the per-output grants
    // never gives an input more than one grant.
    always_comb begin
        sa_grant = '0;
        xbar_sel = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            sa_grant = sa_grant | out_gnt[o];
            xbar_sel[NUM_PORTS*o +: NUM_PORTS] = out_gnt[o];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_q[o] <= OUT_IDLE;
            end
            owner_q  <= '0;
            ptr_q    <= '0;
            err_q    <= '0;
            locked_q <= '0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_q[o] <= state_d[o];
            end
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

    assign out_locked  = locked_q;
    assign proto_error = err_q;

endmodule

// File: tb/tb_wormhole_switch_allocator.sv
// Testbench for wormhole_switch_allocator: directed packet scenarios plus a
// randomized packet stream checked against a behavioural model.
module tb_wormhole_switch_allocator;

    logic        clk;
    logic        rst;
    logic [4:0]  sa_request;
    logic [24:0] outport_req;
    logic [4:0]  is_head;
    logic [4:0]  is_tail;
    logic [4:0]  valid_downstream_ports;
    logic [4:0]  sa_grant;
    logic [24:0] xbar_sel;
    logic [4:0]  out_locked;
    logic [4:0]  proto_error;

    int checks   = 0;
    int failures = 0;

    wormhole_switch_allocator #(.NUM_PORTS(5)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .sa_request             (sa_request),
        .outport_req            (outport_req),
        .is_head                (is_head),
        .is_tail                (is_tail),
        .valid_downstream_ports (valid_downstream_ports),
        .sa_grant               (sa_grant),
        .xbar_sel               (xbar_sel),
        .out_locked             (out_locked),
        .proto_error            (proto_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: per output a lock flag, owner and priority pointer.
    bit         m_locked [5];
    int         m_owner  [5];
    int         m_ptr    [5];
    logic [4:0] m_err;
    bit         n_locked [5];
    int         n_owner  [5];
    int         n_ptr    [5];
    logic [4:0] n_err;
    logic [4:0]  exp_grant;
    logic [24:0] exp_xbar;

    task automatic model_eval();
        int  dest  [5];
        bit  valid [5];
        int  cnt;
        int  cand;
        bit  done;
        n_locked  = m_locked;
        n_owner   = m_owner;
        n_ptr     = m_ptr;
        n_err     = m_err;
        exp_grant = '0;
        exp_xbar  = '0;
        for (int i = 0; i < 5; i++) begin
            valid[i] = 1'b0;
            dest[i]  = -1;
            if (sa_request[i]) begin
                cnt = 0;
                for (int b = 0; b < 5; b++) begin
                    if (outport_req[5*i + b]) begin
                        cnt++;
                        dest[i] = b;
                    end
                end
                if (cnt == 1) valid[i] = 1'b1;
                else          n_err[i] = 1'b1;
            end
        end
        for (int o = 0; o < 5; o++) begin
            if (!m_locked[o]) begin
                for (int i = 0; i < 5; i++) begin
                    if (valid[i] && dest[i] == o && !is_head[i]) n_err[i] = 1'b1;
                end
                done = 1'b0;
                if (valid_downstream_ports[o]) begin
                    for (int k = 0; k < 5; k++) begin
                        cand = (m_ptr[o] + k) % 5;
                        if (!done && valid[cand] && dest[cand] == o && is_head[cand]) begin
                            done = 1'b1;
                            exp_grant[cand] = 1'b1;
                            exp_xbar[5*o + cand] = 1'b1;
                            n_ptr[o] = (cand + 1) % 5;
                            if (!is_tail[cand]) begin
                                n_locked[o] = 1'b1;
                                n_owner[o]  = cand;
                            end
                        end
                    end
                end
            end else begin
                cand = m_owner[o];
                if (valid[cand] && dest[cand] == o) begin
                    if (is_head[cand]) begin
                        n_err[cand] = 1'b1;
                    end else if (valid_downstream_ports[o]) begin
                        exp_grant[cand] = 1'b1;
                        exp_xbar[5*o + cand] = 1'b1;
                        if (is_tail[cand]) n_locked[o] = 1'b0;
                    end
                end
            end
        end
        if (rst) begin
            exp_grant = '0;
            exp_xbar  = '0;
        end
    endtask

    task automatic model_commit();
        for (int o = 0; o < 5; o++) begin
            m_locked[o] = rst ? 1'b0 : n_locked[o];
            m_owner[o]  = rst ? 0    : n_owner[o];
            m_ptr[o]    = rst ? 0    : n_ptr[o];
        end
        m_err = rst ? 5'b0 : n_err;
    endtask

    function automatic logic [4:0] model_locked_vec();
        logic [4:0] v;
        for (int o = 0; o < 5; o++) v[o] = m_locked[o];
        return v;
    endfunction

    // Moves one clock cycle forward from a falling edge to the next one.
    task automatic advance();
        model_eval();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        sa_request  = '0;
        outport_req = '0;
        is_head     = '0;
        is_tail     = '0;
    endtask

    task automatic set_req(input int src, input int dst, input bit head, input bit tail);
        sa_request[src]          = 1'b1;
        outport_req[5*src +: 5]  = 5'(1 << dst);
        is_head[src]             = head;
        is_tail[src]             = tail;
    endtask

    task automatic do_reset();
        clear_inputs();
        valid_downstream_ports = 5'b11111;
        rst = 1'b1;
        advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        valid_downstream_ports = 5'b11111;
        set_req(0, 1, 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        checks++;
        if (sa_grant !== 5'b0 || xbar_sel !== 25'b0) begin
            failures++;
            $display("[TB] FAIL reset_grant_forced actual grant=%b xbar=%b required 0", sa_grant, xbar_sel);
        end
        advance();
        rst = 1'b0;
        clear_inputs();
        #1;
        checks++;
        if (out_locked !== 5'b0 || proto_error !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_state actual locked=%b err=%b required 00000/00000", out_locked, proto_error);
        end
    endtask

    task automatic test_single_flit();
        do_reset();
        set_req(0, 1, 1'b1, 1'b1);
        #1;
        checks++;
        if (sa_grant !== 5'b00001 || xbar_sel[9:5] !== 5'b00001) begin
            failures++;
            $display("[TB] FAIL single_flit_grant actual grant=%b xbar_east=%b required 00001/00001", sa_grant, xbar_sel[9:5]);
        end
        advance();
        clear_inputs();
        #1;
        checks++;
        if (out_locked !== 5'b0) begin
            failures++;
            $display("[TB] FAIL single_flit_lock actual=%b required=00000", out_locked);
        end
    endtask

    task automatic test_contention();
        do_reset();
        set_req(1, 4, 1'b1, 1'b0);
        set_req(2, 4, 1'b1, 1'b0);
        #1;
        checks++;
        if (sa_grant !== 5'b00010 || xbar_sel[24:20] !== 5'b00010) begin
            failures++;
            $display("[TB] FAIL contention_head actual grant=%b xbar_local=%b required 00010/00010", sa_grant, xbar_sel[24:20]);
        end
        advance();
        set_req(1, 4, 1'b0, 1'b0);
        #1;
        checks++;
        if (out_locked !== 5'b10000 || sa_grant !== 5'b00010) begin
            failures++;
            $display("[TB] FAIL contention_body actual locked=%b grant=%b required 10000/00010", out_locked, sa_grant);
        end
        advance();
        set_req(1, 4, 1'b0, 1'b1);
        #1;
        checks++;
        if (sa_grant !== 5'b00010) begin
            failures++;
            $display("[TB] FAIL contention_tail actual=%b required=00010", sa_grant);
        end
        advance();
        clear_inputs();
        set_req(2, 4, 1'b1, 1'b0);
        #1;
        checks++;
        if (out_locked !== 5'b00000 || sa_grant !== 5'b00100 || proto_error !== 5'b0) begin
            failures++;
            $display("[TB] FAIL contention_south actual locked=%b grant=%b err=%b required 00000/00100/00000", out_locked, sa_grant, proto_error);
        end
        advance();
    endtask

    task automatic test_flow_control();
        do_reset();
        set_req(3, 0, 1'b1, 1'b0);
        #1;
        checks++;
        if (sa_grant !== 5'b01000 || xbar_sel[4:0] !== 5'b01000) begin
            failures++;
            $display("[TB] FAIL flow_head actual grant=%b xbar_north=%b required 01000/01000", sa_grant, xbar_sel[4:0]);
        end
        advance();
        set_req(3, 0, 1'b0, 1'b0);
        valid_downstream_ports = 5'b11110;
        #1;
        checks++;
        if (sa_grant !== 5'b0 || xbar_sel[4:0] !== 5'b0) begin
            failures++;
            $display("[TB] FAIL flow_stall actual grant=%b xbar_north=%b required 00000/00000", sa_grant, xbar_sel[4:0]);
        end
        advance();
        set_req(3, 0, 1'b0, 1'b1);
        valid_downstream_ports = 5'b11111;
        #1;
        checks++;
        if (out_locked !== 5'b00001 || sa_grant !== 5'b01000) begin
            failures++;
            $display("[TB] FAIL flow_resume actual locked=%b grant=%b required 00001/01000", out_locked, sa_grant);
        end
        advance();
        clear_inputs();
        #1;
        checks++;
        if (out_locked !== 5'b0) begin
            failures++;
            $display("[TB] FAIL flow_release actual=%b required=00000", out_locked);
        end
    endtask

    task automatic test_proto_error();
        do_reset();
        sa_request[0]   = 1'b1;
        outport_req[4:0] = 5'b00011;
        is_head[0]      = 1'b1;
        is_tail[0]      = 1'b1;
        #1;
        checks++;
        if (sa_grant !== 5'b0) begin
            failures++;
            $display("[TB] FAIL bad_onehot_grant actual=%b required=00000", sa_grant);
        end
        advance();
        clear_inputs();
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (proto_error !== 5'b00001) begin
                failures++;
                $display("[TB] FAIL bad_onehot_sticky cycle %0d actual=%b required=00001", c, proto_error);
            end
            advance();
        end
    endtask

    task automatic test_rotation();
        logic [4:0] expected [6];
        expected = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < 5; i++) set_req(i, 4, 1'b1, 1'b1);
            #1;
            checks++;
            if (sa_grant !== expected[c]) begin
                failures++;
                $display("[TB] FAIL rotation cycle %0d actual=%b required=%b", c, sa_grant, expected[c]);
            end
            advance();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        set_req(4, 2, 1'b1, 1'b0);
        #1;
        checks++;
        if (sa_grant !== 5'b10000) begin
            failures++;
            $display("[TB] FAIL midreset_head actual=%b required=10000", sa_grant);
        end
        advance();
        set_req(4, 2, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (out_locked !== 5'b00100 || sa_grant !== 5'b0 || xbar_sel !== 25'b0) begin
            failures++;
            $display("[TB] FAIL midreset_during actual locked=%b grant=%b xbar=%b required 00100/0/0", out_locked, sa_grant, xbar_sel);
        end
        advance();
        rst = 1'b0;
        clear_inputs();
        set_req(0, 2, 1'b1, 1'b0);
        #1;
        checks++;
        if (out_locked !== 5'b0 || sa_grant !== 5'b00001 || xbar_sel[14:10] !== 5'b00001) begin
            failures++;
            $display("[TB] FAIL midreset_after actual locked=%b grant=%b xbar_south=%b required 00000/00001/00001", out_locked, sa_grant, xbar_sel[14:10]);
        end
        advance();
        clear_inputs();
    endtask

    // Random packet streams: inputs start packets with heads, follow with
    // body/tail flits once their head was granted, plus occasional malformed
    // output selects, flow-control stalls and resets.
    task automatic test_random();
        bit         in_pkt [5];
        int         dst    [5];
        logic [4:0] bad;
        logic [4:0] exp_lock;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_pkt[i] = 1'b0;
            dst[i]    = 0;
        end
        for (int c = 0; c < 400; c++) begin
            clear_inputs();
            rst = ($urandom_range(0, 199) == 0);
            for (int o = 0; o < 5; o++) valid_downstream_ports[o] = ($urandom_range(0, 99) < 85);
            for (int i = 0; i < 5; i++) begin
                if ($urandom_range(0, 99) < 70) begin
                    if ($urandom_range(0, 99) < 2) begin
                        bad = 5'($urandom_range(0, 31));
                        if ($countones(bad) == 1) bad = 5'b0;
                        sa_request[i]         = 1'b1;
                        outport_req[5*i +: 5] = bad;
                        is_head[i]            = 1'($urandom_range(0, 1));
                    end else if (in_pkt[i]) begin
                        set_req(i, dst[i], 1'b0, $urandom_range(0, 2) == 0);
                    end else begin
                        dst[i] = $urandom_range(0, 4);
                        set_req(i, dst[i], 1'b1, $urandom_range(0, 3) == 0);
                    end
                end
            end
            #1;
            model_eval();
            exp_lock = model_locked_vec();
            checks++;
            if (sa_grant !== exp_grant) begin
                failures++;
                $display("[TB] FAIL random_grant cycle %0d actual=%b required=%b", c, sa_grant, exp_grant);
            end
            checks++;
            if (xbar_sel !== exp_xbar) begin
                failures++;
                $display("[TB] FAIL random_xbar cycle %0d actual=%b required=%b", c, xbar_sel, exp_xbar);
            end
            checks++;
            if (out_locked !== exp_lock) begin
                failures++;
                $display("[TB] FAIL random_locked cycle %0d actual=%b required=%b", c, out_locked, exp_lock);
            end
            checks++;
            if (proto_error !== m_err) begin
                failures++;
                $display("[TB] FAIL random_proto_error cycle %0d actual=%b required=%b", c, proto_error, m_err);
            end
            for (int i = 0; i < 5; i++) begin
                if (rst) begin
                    in_pkt[i] = 1'b0;
                end else if (exp_grant[i] && sa_request[i]) begin
                    if (is_tail[i])      in_pkt[i] = 1'b0;
                    else if (is_head[i]) in_pkt[i] = 1'b1;
                end
            end
            advance();
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        valid_downstream_ports = 5'b11111;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_single_flit();
        test_contention();
        test_flow_control();
        test_proto_error();
        test_rotation();
        test_reset_mid_packet();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wormhole_switch_allocator.md
WORMHOLE_SWITCH_ALLOCATOR -- requirements
Module: wormhole_switch_allocator

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 5, meaning number of router ports; only 5 is supported (bit order 0 north, 1 east, 2 south, 3 west, 4 local).
REQ-002 SHALL have port clk  input  1  single clock for all state.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port sa_request  input  5  per-input flit ready for traversal.
REQ-005 SHALL have port outport_req  input  25  one-hot requested output per input; bits [5i+4:5i] belong to input i.
REQ-006 SHALL have port is_head  input  5  per-input: requesting flit is a head flit.
REQ-007 SHALL have port is_tail  input  5  per-input: requesting flit is a tail flit (head+tail = single-flit packet).
REQ-008 SHALL have port valid_downstream_ports  input  5  per-output on/off flow control; 1 = downstream buffer on.
REQ-009 SHALL have port sa_grant  output  5  per-input grant, same cycle as request.
REQ-010 SHALL have port xbar_sel  output  25  one-hot source input per output; bits [5o+4:5o] belong to output o; all-zero = output unused.
REQ-011 SHALL have port out_locked  output  5  registered per-output wormhole lock status.
REQ-012 SHALL have port proto_error  output  5  registered sticky per-input protocol error flag.

Function
REQ-013 SHALL keep per output o a state IDLE or LOCKED(owner), plus a 3-bit round-robin pointer.
REQ-014 SHALL treat a request as valid only if sa_request[i]=1 and outport_req for input i is exactly one-hot; otherwise it SHALL be ignored and, when sa_request[i]=1, set proto_error[i] on the next edge.
REQ-015 IDLE output, downstream on: SHALL arbitrate among valid head requests for it; winner is the first requester at or after the pointer, wrapping 4->0.
REQ-016 Body/tail request (is_head=0) to IDLE output SHALL NOT be granted and SHALL set proto_error[i].
REQ-017 LOCKED output, downstream on: SHALL grant only the owner's non-head request; non-owner requests SHALL wait without error.
REQ-018 A head request from the owner of a LOCKED output SHALL NOT be granted and SHALL set proto_error[i].
REQ-019 Downstream off (valid_downstream_ports[o]=0): SHALL grant nothing to output o; lock state and pointer SHALL be held.
REQ-020 sa_grant and xbar_sel SHALL be combinational from inputs and registered state (zero-cycle latency); xbar_sel[o] equals the one-hot granted input or zero.
REQ-021 On a granted head without tail, output SHALL become LOCKED(winner) at the next edge; pointer SHALL become (winner+1) mod 5.
REQ-022 On a granted head+tail, output SHALL stay IDLE; pointer SHALL become (winner+1) mod 5.
REQ-023 On a granted owner tail, output SHALL return to IDLE at the next edge; new heads are eligible from that cycle on, never in the tail cycle.
REQ-024 Each input SHALL receive at most one grant per cycle; each output SHALL grant at most one input per cycle.
REQ-025 out_locked[o] SHALL be 1 exactly while output o is LOCKED.
REQ-026 proto_error bits SHALL remain set until reset.

Reset
REQ-027 On rst=1 at a clock edge, all outputs SHALL go IDLE, all pointers SHALL be 0, and out_locked and proto_error SHALL be 0.
REQ-028 While rst=1, sa_grant and xbar_sel SHALL be forced to 0.
REQ-029 Reset mid-packet SHALL drop all locks; no lock SHALL persist past reset.

Structure
REQ-030 Package router_pkg SHALL hold NUM_PORTS, the port-index constants (PORT_NORTH=0 .. PORT_LOCAL=4) and the output-state enum {OUT_IDLE, OUT_LOCKED}.
REQ-031 SHALL instantiate one sub-module rr_pick5 per output: a combinational 5-way round-robin picker with inputs req[4:0] and ptr[2:0], and output gnt[4:0].

Verification
REQ-032 Single head+tail from north to east, downstream on -> sa_grant=00001, xbar_sel[east]=00001 same cycle; out_locked stays 00000.
REQ-033 East and south heads to local together, pointer 0 -> east granted, local locked by east; south blocked until east tail; south granted the cycle after the tail.
REQ-034 3-flit packet west->north with valid_downstream_ports[north]=0 in cycle 2 -> no grant in cycle 2; lock held; body granted when flow control returns to 1.
REQ-035 outport_req for input 0 = 00011 -> no grant; proto_error[0]=1 next cycle and sticky.
REQ-036 All 5 inputs repeatedly send single-flit heads to local -> grants rotate north, east, south, west, local, north.
REQ-037 rst asserted while south is locked by local -> out_locked=00000 next cycle; a fresh head from any input to south is granted.
